// File: rtl/ir_nec_decoder.sv
// ir_nec_decoder: decodes NEC infrared remote frames from a demodulated receiver
// and drives the 3-bit motion code consumed by the command transmitter.
// Optional macro NEC_CHECKSUM_EN: reject frames whose complement bytes do not match.
module ir_nec_decoder #(
  parameter int TICK_CLKS     = 2813,
  parameter int TIMEOUT_TICKS = 200,
  parameter int HOLD_TICKS    = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_n,
  output logic [2:0] state_control,
  output logic [7:0] cmd_code,
  output logic [7:0] addr,
  output logic       cmd_valid,
  output logic       rpt_valid,
  output logic       frame_err
);

  localparam int PRESC_W = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam int HOLD_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(TICK_CLKS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [7:0]         TIMEOUT_DUR = 8'(TIMEOUT_TICKS);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    RPT_MARK
  } state_t;

  logic              sync1_q, sync2_q, prev_q;
  logic              riseEdge, fallEdge, anyEdge;
  logic [PRESC_W-1:0] presc_q;
  logic              tick;
  logic [7:0]        dur_q;
  logic              isLeadMark, isLeadSpace, isRptSpace, isShort, isOneSpace;
  logic              checksumOk;
  logic              abortFrame;

  state_t            state_q, state_d;
  logic [4:0]        bitCnt_q, bitCnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [2:0]        stateCtl_q, stateCtl_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        addr_q, addr_d;
  logic              cmdValid_q, cmdValid_d;
  logic              rptValid_q, rptValid_d;
  logic              frameErr_q, frameErr_d;
  logic              haveCmd_q, haveCmd_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Map a received command byte to a motion code; unknown commands keep the current code.
  function automatic logic [2:0] mapCmd(input logic [7:0] cmd, input logic [2:0] cur);
    case (cmd)
      8'h1C:   mapCmd = 3'b000;
      8'h08:   mapCmd = 3'b001;
      8'h5A:   mapCmd = 3'b010;
      8'h18:   mapCmd = 3'b011;
      8'h0D:   mapCmd = 3'b101;
      default: mapCmd = cur;
    endcase
  endfunction

  // Two-flop synchronizer plus a delayed copy for edge detection. Reset loads 0 so a
  // mark already in progress when reset releases never produces a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= ir_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign riseEdge = sync2_q & ~prev_q;
  assign fallEdge = ~sync2_q & prev_q;
  assign anyEdge  = riseEdge | fallEdge;
  assign tick     = (presc_q == PRESC_LAST);

  // Free-running prescaler producing one timing tick every TICK_CLKS clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Length of the current line level in ticks: cleared on each edge, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      dur_q <= 8'd0;
    end else if (anyEdge) begin
      dur_q <= 8'd0;
    end else if (tick && (dur_q != 8'hFF)) begin
      dur_q <= dur_q + 8'd1;
    end
  end

  assign isLeadMark  = (dur_q >= 8'd144) && (dur_q <= 8'd176);
  assign isLeadSpace = (dur_q >= 8'd72)  && (dur_q <= 8'd88);
  assign isRptSpace  = (dur_q >= 8'd36)  && (dur_q <= 8'd44);
  assign isShort     = (dur_q >= 8'd7)   && (dur_q <= 8'd13);
  assign isOneSpace  = (dur_q >= 8'd26)  && (dur_q <= 8'd34);

`ifdef NEC_CHECKSUM_EN
  assign checksumOk = (shift_q[15:8] == ~shift_q[7:0]) && (shift_q[31:24] == ~shift_q[23:16]);
`else
  logic unusedBits;
  assign checksumOk = 1'b1;
  assign unusedBits = ^{shift_q[31:24], shift_q[15:8]};
`endif

  // Frame FSM, hold timer and output updates. The hold expiry is applied first so a
  // frame or repeat accepted in the same cycle overrides it and restarts the timer.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    stateCtl_d = stateCtl_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    haveCmd_d  = haveCmd_q;
    hold_d     = hold_q;
    cmdValid_d = 1'b0;
    rptValid_d = 1'b0;
    frameErr_d = 1'b0;
    abortFrame = 1'b0;

    if (haveCmd_q && tick) begin
      if (hold_q == HOLD_LAST) begin
        hold_d     = '0;
        haveCmd_d  = 1'b0;
        stateCtl_d = 3'b000;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (fallEdge) state_d = LEAD_MARK;
      end
      LEAD_MARK: begin
        if (riseEdge) begin
          if (isLeadMark) state_d = LEAD_SPACE;
          else abortFrame = 1'b1;
        end
      end
      LEAD_SPACE: begin
        if (fallEdge) begin
          if (isLeadSpace) begin
            state_d  = BIT_MARK;
            bitCnt_d = 5'd0;
          end else if (isRptSpace) begin
            state_d = RPT_MARK;
          end else begin
            abortFrame = 1'b1;
          end
        end
      end
      BIT_MARK: begin
        if (riseEdge) begin
          if (isShort) state_d = BIT_SPACE;
          else abortFrame = 1'b1;
        end
      end
      BIT_SPACE: begin
        if (fallEdge) begin
          if (isShort || isOneSpace) begin
            shift_d  = {isOneSpace, shift_q[31:1]};
            bitCnt_d = bitCnt_q + 5'd1;
            state_d  = (bitCnt_q == 5'd31) ? STOP_MARK : BIT_MARK;
          end else begin
            abortFrame = 1'b1;
          end
        end
      end
      STOP_MARK: begin
        if (riseEdge) begin
          if (isShort && checksumOk) begin
            addr_d     = shift_q[7:0];
            cmd_d      = shift_q[23:16];
            stateCtl_d = mapCmd(shift_q[23:16], stateCtl_q);
            cmdValid_d = 1'b1;
            haveCmd_d  = 1'b1;
            hold_d     = '0;
            state_d    = IDLE;
          end else begin
            abortFrame = 1'b1;
          end
        end
      end
      RPT_MARK: begin
        if (riseEdge) begin
          if (isShort && haveCmd_q) begin
            rptValid_d = 1'b1;
            haveCmd_d  = 1'b1;
            hold_d     = '0;
            stateCtl_d = stateCtl_q;
            state_d    = IDLE;
          end else begin
            abortFrame = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && !anyEdge && (dur_q >= TIMEOUT_DUR)) abortFrame = 1'b1;

    if (abortFrame) begin
      frameErr_d = 1'b1;
      state_d    = IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bitCnt_q   <= 5'd0;
      shift_q    <= 32'd0;
      stateCtl_q <= 3'b000;
      cmd_q      <= 8'd0;
      addr_q     <= 8'd0;
      cmdValid_q <= 1'b0;
      rptValid_q <= 1'b0;
      frameErr_q <= 1'b0;
      haveCmd_q  <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      stateCtl_q <= stateCtl_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      cmdValid_q <= cmdValid_d;
      rptValid_q <= rptValid_d;
      frameErr_q <= frameErr_d;
      haveCmd_q  <= haveCmd_d;
      hold_q     <= hold_d;
    end
  end

  assign state_control = stateCtl_q;
  assign cmd_code      = cmd_q;
  assign addr          = addr_q;
  assign cmd_valid     = cmdValid_q;
  assign rpt_valid     = rptValid_q;
  assign frame_err     = frameErr_q;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// tb_ir_nec_decoder: directed NEC waveforms with a scoreboard queue; a monitor pops
// and compares one expected entry every time the decoder pulses an output.
module tb_ir_nec_decoder;

  localparam int T       = 2;
  localparam int TIMEOUT = 200;
  localparam int HOLD    = 4000;

  localparam logic [2:0] EV_CMD = 3'b001;
  localparam logic [2:0] EV_RPT = 3'b010;
  localparam logic [2:0] EV_ERR = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] addr;
    logic [7:0] cmd;
    logic [2:0] st;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       ir_n;
  logic [2:0] state_control;
  logic [7:0] cmd_code;
  logic [7:0] addr;
  logic       cmd_valid;
  logic       rpt_valid;
  logic       frame_err;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycleCount = 0;
  int   eventCycle = 0;
  int   edgeCycle  = 0;

  ir_nec_decoder #(
    .TICK_CLKS    (T),
    .TIMEOUT_TICKS(TIMEOUT),
    .HOLD_TICKS   (HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ir_n         (ir_n),
    .state_control(state_control),
    .cmd_code     (cmd_code),
    .addr         (addr),
    .cmd_valid    (cmd_valid),
    .rpt_valid    (rpt_valid),
    .frame_err    (frame_err)
  );

  // 100 MHz-style free-running bench clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time hold expiry and frame timeout.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checkCount++;
    if (actual >= lo && actual <= hi) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
  endtask

  task automatic pushExp(input logic [2:0] kind, input logic [7:0] a, input logic [7:0] c, input logic [2:0] s);
    exp_t e;
    e.kind = kind;
    e.addr = a;
    e.cmd  = c;
    e.st   = s;
    expQ.push_back(e);
  endtask

  // Drive one line level for a number of ticks; always entered and left on a falling clock edge.
  task automatic holdLevel(input logic lvl, input int ticks);
    ir_n      = lvl;
    edgeCycle = cycleCount;
    repeat (ticks * T) @(negedge clk);
  endtask

  // Full NEC frame, LSB first, followed by an idle-high gap.
  task automatic applyStimulus(input logic [31:0] word, input int gap);
    holdLevel(1'b0, 160);
    holdLevel(1'b1, 80);
    for (int i = 0; i < 32; i++) begin
      holdLevel(1'b0, 10);
      holdLevel(1'b1, word[i] ? 30 : 10);
    end
    holdLevel(1'b0, 10);
    holdLevel(1'b1, gap);
  endtask

  task automatic sendRepeat(input int gap);
    holdLevel(1'b0, 160);
    holdLevel(1'b1, 40);
    holdLevel(1'b0, 10);
    holdLevel(1'b1, gap);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (expQ.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL drainTimeout: got %0d pending events, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  // Monitor: every pulse on cmd_valid/rpt_valid/frame_err consumes one scoreboard entry.
  initial begin : monitor
    exp_t       e;
    logic [2:0] got;
    forever begin
      @(negedge clk);
      got = {frame_err, rpt_valid, cmd_valid};
      if (rst !== 1'b1 && got != 3'b000) begin
        eventCycle = cycleCount;
        checkCount++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL unexpectedEvent: got kind=%b addr=%h cmd=%h st=%b, expected no event",
                   got, addr, cmd_code, state_control);
        end else begin
          e = expQ.pop_front();
          if (got === e.kind && addr === e.addr && cmd_code === e.cmd && state_control === e.st)
            passCount++;
          else
            $display("[TB] FAIL event: got kind=%b addr=%h cmd=%h st=%b, expected kind=%b addr=%h cmd=%h st=%b",
                     got, addr, cmd_code, state_control, e.kind, e.addr, e.cmd, e.st);
        end
      end
    end
  end

  initial begin : stimulus
    logic [2:0]  ckStExp;
    logic [7:0]  ckCmdExp;
    logic [31:0] truncWord;
    int          n;
    int          startCyc;

    rst  = 1'b1;
    ir_n = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset values");
    checkOutput("resetState", {29'd0, state_control}, 32'd0);
    checkOutput("resetCmd", {24'd0, cmd_code}, 32'd0);
    checkOutput("resetAddr", {24'd0, addr}, 32'd0);
    checkOutput("resetCmdValid", {31'd0, cmd_valid}, 32'd0);
    checkOutput("resetRptValid", {31'd0, rpt_valid}, 32'd0);
    checkOutput("resetFrameErr", {31'd0, frame_err}, 32'd0);

    $display("[TB] repeat code with no prior frame");
    pushExp(EV_ERR, 8'h00, 8'h00, 3'b000);
    sendRepeat(200);
    waitDrain(100);
    checkOutput("orphanRptState", {29'd0, state_control}, 32'd0);

    $display("[TB] frame addr 00 cmd 18 then repeats every 108 ms");
    pushExp(EV_CMD, 8'h00, 8'h18, 3'b011);
    applyStimulus(32'hE718FF00, 700);
    for (int i = 0; i < 9; i++) begin
      pushExp(EV_RPT, 8'h00, 8'h18, 3'b011);
      sendRepeat((i == 8) ? 5 : 1710);
    end
    waitDrain(100);
    startCyc = eventCycle;
    n = 0;
    while (state_control !== 3'b000 && n < (HOLD + 4) * T) begin
      @(negedge clk);
      n++;
    end
    checkRange("holdExpiry", cycleCount - startCyc, (HOLD - 1) * T, (HOLD + 1) * T);

    $display("[TB] cmd 5A with bad complement byte");
`ifdef NEC_CHECKSUM_EN
    pushExp(EV_ERR, 8'h00, 8'h18, 3'b000);
    ckStExp  = 3'b000;
    ckCmdExp = 8'h18;
`else
    pushExp(EV_CMD, 8'h00, 8'h5A, 3'b010);
    ckStExp  = 3'b010;
    ckCmdExp = 8'h5A;
`endif
    applyStimulus(32'h005AFF00, 200);
    waitDrain(100);
    checkOutput("checksumState", {29'd0, state_control}, {29'd0, ckStExp});

    $display("[TB] short leader mark then nominal 08 frame");
    pushExp(EV_ERR, 8'h00, ckCmdExp, ckStExp);
    holdLevel(1'b0, 133);
    holdLevel(1'b1, 200);
    waitDrain(100);
    pushExp(EV_CMD, 8'h00, 8'h08, 3'b001);
    applyStimulus(32'hF708FF00, 200);
    waitDrain(100);
    checkOutput("afterBadLeaderState", {29'd0, state_control}, 32'd1);

    $display("[TB] frame truncated after 12 bits");
    truncWord = 32'hE718FF00;
    pushExp(EV_ERR, 8'h00, 8'h08, 3'b001);
    holdLevel(1'b0, 160);
    holdLevel(1'b1, 80);
    for (int i = 0; i < 12; i++) begin
      holdLevel(1'b0, 10);
      if (i < 11) holdLevel(1'b1, truncWord[i] ? 30 : 10);
    end
    ir_n      = 1'b1;
    edgeCycle = cycleCount;
    waitDrain((TIMEOUT + 10) * T);
    checkRange("timeoutDelay", eventCycle - edgeCycle, (TIMEOUT - 1) * T, (TIMEOUT + 1) * T + 6);

    $display("[TB] mapped and unmapped commands");
    pushExp(EV_CMD, 8'h00, 8'h1C, 3'b000);
    applyStimulus(32'hE31CFF00, 200);
    pushExp(EV_CMD, 8'hA3, 8'h0D, 3'b101);
    applyStimulus(32'hF20D5CA3, 200);
    pushExp(EV_CMD, 8'h55, 8'h33, 3'b101);
    applyStimulus(32'hCC33AA55, 200);
    waitDrain(100);
    checkOutput("unmappedAddr", {24'd0, addr}, 32'h55);

    $display("[TB] reset in the middle of a frame");
    holdLevel(1'b0, 160);
    holdLevel(1'b1, 80);
    for (int i = 0; i < 5; i++) begin
      holdLevel(1'b0, 10);
      holdLevel(1'b1, 10);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    holdLevel(1'b1, TIMEOUT + 100);
    checkOutput("midResetState", {29'd0, state_control}, 32'd0);
    checkOutput("midResetCmd", {24'd0, cmd_code}, 32'd0);
    checkOutput("midResetAddr", {24'd0, addr}, 32'd0);

    checkOutput("pendingEvents", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
